// File: rtl/mems_spi_arbiter_if.sv
// Signal bundle between the scan/host requesters, the arbiter and the DAC SPI master.
// The master modport is the arbiter side; the slave modport is the requester/SPI-master side.
interface mems_spi_arbiter_if #(
   parameter int DATA_W = 24
);
   logic              scan_req;
   logic [DATA_W-1:0] scan_data;
   logic              scan_ack;
   logic              host_req;
   logic [DATA_W-1:0] host_data;
   logic              host_lock;
   logic              host_ack;
   logic              spi_start;
   logic [DATA_W-1:0] spi_data;
   logic              spi_busy;
   logic              grant_host;
   logic              err_timeout;

   modport master (
      input  scan_req, scan_data, host_req, host_data, host_lock, spi_busy,
      output scan_ack, host_ack, spi_start, spi_data, grant_host, err_timeout
   );

   modport slave (
      output scan_req, scan_data, host_req, host_data, host_lock, spi_busy,
      input  scan_ack, host_ack, spi_start, spi_data, grant_host, err_timeout
   );
endinterface

// File: rtl/mems_spi_arbiter.sv
// Two-requester arbiter for the MEMS DAC SPI master: start pulse on the cycle after arbitration, one-cycle ack after busy falls.
// Requests are held until ack; optional per-phase watchdog is enabled with MEMS_ARB_WATCHDOG_EN.
module mems_spi_arbiter #(
   parameter int DATA_W        = 24,
   parameter int HOST_MAX_WAIT = 4,
   parameter int TIMEOUT       = 4096
) (
   input  logic               clk,
   input  logic               rst,
   mems_spi_arbiter_if.master arb_io
);
   typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_IDLE, DONE} state_t;

   localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

   if (HOST_MAX_WAIT < 1 || HOST_MAX_WAIT > 15 || TIMEOUT < 2) begin : g_bad_param
      $error("mems_spi_arbiter: HOST_MAX_WAIT must be 1..15 and TIMEOUT at least 2");
   end

   state_t            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              owner_host_q, owner_host_d;
   logic              lock_q, lock_d;
   logic [3:0]        streak_q, streak_d;
   logic              take_host, take_scan;
   logic              wd_hit;

   always_comb begin
      take_host = 1'b0;
      take_scan = 1'b0;
      if (state_q == IDLE) begin
         // A held lock starves scan even when host has nothing queued.
         if (lock_q && arb_io.host_lock) begin
            take_host = arb_io.host_req;
         end else begin
            take_host = arb_io.host_req && (!arb_io.scan_req || streak_q == MAX_WAIT);
            take_scan = arb_io.scan_req && !take_host;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      data_d       = data_q;
      owner_host_d = owner_host_q;
      lock_d       = lock_q;
      streak_d     = streak_q;
      unique case (state_q)
         IDLE: begin
            if (!arb_io.host_lock) lock_d = 1'b0;
            if (take_host) begin
               data_d       = arb_io.host_data;
               owner_host_d = 1'b1;
               streak_d     = 4'd0;
               state_d      = START;
            end else if (take_scan) begin
               data_d       = arb_io.scan_data;
               owner_host_d = 1'b0;
               if (!arb_io.host_req)          streak_d = 4'd0;
               else if (streak_q != MAX_WAIT) streak_d = streak_q + 4'd1;
               state_d      = START;
            end
         end
         START:     state_d = WAIT_BUSY;
         WAIT_BUSY: if (wd_hit) state_d = DONE; else if (arb_io.spi_busy)  state_d = WAIT_IDLE;
         WAIT_IDLE: if (wd_hit) state_d = DONE; else if (!arb_io.spi_busy) state_d = DONE;
         DONE: begin
            if (owner_host_q && arb_io.host_lock) lock_d = 1'b1;
            state_d = IDLE;
         end
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         data_q       <= '0;
         owner_host_q <= 1'b0;
         lock_q       <= 1'b0;
         streak_q     <= 4'd0;
      end else begin
         state_q      <= state_d;
         data_q       <= data_d;
         owner_host_q <= owner_host_d;
         lock_q       <= lock_d;
         streak_q     <= streak_d;
      end
   end

`ifdef MEMS_ARB_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wd_q;
   logic            timeout_q;

   assign wd_hit = (state_q == WAIT_BUSY || state_q == WAIT_IDLE) &&
                   (wd_q == WD_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || state_q != state_d) wd_q <= '0;
      else if (state_q == WAIT_BUSY || state_q == WAIT_IDLE) wd_q <= wd_q + 1'b1;
   end

   // Captured on the forcing edge so the flag lines up with the DONE-cycle ack.
   always_ff @(posedge clk) begin
      if (rst) timeout_q <= 1'b0;
      else     timeout_q <= wd_hit;
   end

   assign arb_io.err_timeout = timeout_q;
`else
   assign wd_hit             = 1'b0;
   assign arb_io.err_timeout = 1'b0;
`endif

   assign arb_io.spi_start  = (state_q == START);
   assign arb_io.spi_data   = data_q;
   assign arb_io.scan_ack   = (state_q == DONE) && !owner_host_q;
   assign arb_io.host_ack   = (state_q == DONE) &&  owner_host_q;
   assign arb_io.grant_host = (owner_host_q && state_q != IDLE) || lock_q;
endmodule

// File: tb/tb_mems_spi_arbiter.sv
// Directed bench for mems_spi_arbiter: a scoreboard of expected SPI words/owners is checked at every start and ack.
`timescale 1ns/1ps
module tb_mems_spi_arbiter;
   localparam int DW = 24;

   typedef struct {
      logic          host;
      logic [DW-1:0] data;
   } xfer_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mems_spi_arbiter_if #(.DATA_W(DW)) bus ();

   mems_spi_arbiter #(.DATA_W(DW), .HOST_MAX_WAIT(4), .TIMEOUT(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .arb_io (bus.master)
   );

   xfer_t exp_q[$];
   int    tests = 0;
   int    fails = 0;
   int    starts = 0;
   int    scan_acks = 0;
   int    host_acks = 0;
   logic  pend_vld = 1'b0;
   logic  pend_host = 1'b0;

   // SPI master model: busy rises the cycle after start and stays high busy_len cycles.
   int busy_len = 10;
   bit busy_stuck = 1'b0;
   int bcnt;
   always @(posedge clk) begin
      if (rst) begin
         bus.spi_busy <= 1'b0;
         bcnt         <= 0;
      end else if (bus.spi_start && !busy_stuck) begin
         bus.spi_busy <= 1'b1;
         bcnt         <= busy_len;
      end else if (bus.spi_busy) begin
         if (bcnt == 1) bus.spi_busy <= 1'b0;
         bcnt <= bcnt - 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: pop the scoreboard on every start, match every ack to the outstanding owner.
   initial begin
      xfer_t x;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend_vld = 1'b0;
         end else begin
            if (bus.spi_start) begin
               starts++;
               check("start_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  x = exp_q.pop_front();
                  check("start_owner", 32'(bus.grant_host), 32'(x.host));
                  check("start_data", 32'(bus.spi_data), 32'(x.data));
                  pend_vld  = 1'b1;
                  pend_host = x.host;
               end
            end
            if (bus.scan_ack || bus.host_ack) begin
               check("ack_pending", 32'(pend_vld), 1);
               check("ack_owner", 32'({bus.host_ack, bus.scan_ack}), pend_host ? 32'd2 : 32'd1);
               pend_vld = 1'b0;
               if (bus.scan_ack) scan_acks++;
               if (bus.host_ack) host_acks++;
            end
         end
      end
   end

   task automatic push(input logic host, input logic [DW-1:0] data);
      xfer_t x;
      x.host = host;
      x.data = data;
      exp_q.push_back(x);
   endtask

   // Returns at the negedge inside the ack cycle.
   task automatic wait_ack(input string tag, output logic host);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.scan_ack || bus.host_ack) && n < 200);
      check({tag, "_ack_in_time"}, 32'(n < 200), 1);
      host = bus.host_ack;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, observed hang expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic h;
      int   n;
      int   si;
      int   hi;
      int   scan_before;

      rst = 1'b1;
      bus.scan_req = 1'b0; bus.scan_data = '0;
      bus.host_req = 1'b0; bus.host_data = '0; bus.host_lock = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", 32'({bus.spi_start, bus.scan_ack, bus.host_ack, bus.grant_host, bus.err_timeout}), 0);
      check("rst_data", 32'(bus.spi_data), 0);
      rst = 1'b0;

      // Single scan word.
      @(posedge clk); #1;
      bus.scan_data = 24'h031234;
      bus.scan_req  = 1'b1;
      push(1'b0, 24'h031234);
      check("start_not_early", 32'(bus.spi_start), 0);
      @(posedge clk); #1;
      check("start_latency", 32'(bus.spi_start), 1);
      check("start_word", 32'(bus.spi_data), 32'h031234);
      n = 0;
      while (!bus.spi_busy && n < 10) begin @(posedge clk); #1; n++; end
      while (bus.spi_busy && n < 40) begin @(posedge clk); #1; n++; end
      check("busy_cycle_seen", 32'(n < 40), 1);
      check("ack_not_early", 32'(bus.scan_ack), 0);
      @(posedge clk); #1;
      check("ack_after_busy", 32'(bus.scan_ack), 1);
      @(posedge clk); #1;
      bus.scan_req = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("no_reissue", starts, 1);

      // Both requesters held: four scans then a host, twice.
      si = 0; hi = 0;
      for (int g = 0; g < 10; g++) begin
         if (g % 5 == 4) push(1'b1, 24'h0B0000 + 24'(g / 5));
         else            push(1'b0, 24'h0A0000 + 24'(g - g / 5));
      end
      bus.scan_data = 24'h0A0000;
      bus.host_data = 24'h0B0000;
      bus.scan_req  = 1'b1;
      bus.host_req  = 1'b1;
      for (int g = 0; g < 10; g++) begin
         wait_ack("fair", h);
         @(posedge clk); #1;
         if (h) begin
            check("streak_clear", 32'(dut.streak_q), 0);
            hi++;
            bus.host_data = 24'h0B0000 + 24'(hi);
         end else begin
            si++;
            bus.scan_data = 24'h0A0000 + 24'(si);
         end
         if (g == 9) begin
            bus.scan_req = 1'b0;
            bus.host_req = 1'b0;
         end
      end

      // Locked host burst while scan waits.
      push(1'b1, 24'h100000);
      push(1'b1, 24'h200001);
      push(1'b1, 24'h300002);
      push(1'b0, 24'h0C0000);
      bus.host_lock = 1'b1;
      bus.host_data = 24'h100000;
      bus.host_req  = 1'b1;
      wait_ack("lock1", h);
      @(posedge clk); #1;
      check("lock_hold", 32'(bus.grant_host), 1);
      bus.host_data = 24'h200001;
      bus.scan_data = 24'h0C0000;
      bus.scan_req  = 1'b1;
      wait_ack("lock2", h);
      @(posedge clk); #1;
      bus.host_data = 24'h300002;
      wait_ack("lock3", h);
      @(posedge clk); #1;
      bus.host_lock = 1'b0;
      bus.host_req  = 1'b0;
      wait_ack("post_lock", h);
      check("post_lock_scan", 32'(h), 0);
      @(posedge clk); #1;
      bus.scan_req = 1'b0;
      check("grant_released", 32'(bus.grant_host), 0);

      // Reset in WAIT_IDLE of a scan word, then the held request is reissued.
      scan_before = scan_acks;
      push(1'b0, 24'h0D0000);
      push(1'b0, 24'h0D0000);
      bus.scan_data = 24'h0D0000;
      bus.scan_req  = 1'b1;
      n = 0;
      while (!bus.spi_busy && n < 10) begin @(posedge clk); #1; n++; end
      check("rst_busy_seen", 32'(bus.spi_busy), 1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_outputs", 32'({bus.spi_start, bus.scan_ack, bus.host_ack, bus.grant_host, bus.err_timeout}), 0);
      check("abort_data", 32'(bus.spi_data), 0);
      rst = 1'b0;
      wait_ack("reissue", h);
      @(posedge clk); #1;
      bus.scan_req = 1'b0;
      check("reissue_one_ack", scan_acks - scan_before, 1);

      // Busy never rises after start.
      busy_stuck = 1'b1;
      push(1'b1, 24'h0E0000);
      bus.host_data = 24'h0E0000;
      bus.host_req  = 1'b1;
      n = 0;
      while (!bus.spi_start && n < 10) begin @(posedge clk); #1; n++; end
      check("wd_start_seen", 32'(bus.spi_start), 1);
      @(posedge clk);
`ifdef MEMS_ARB_WATCHDOG_EN
      repeat (15) @(posedge clk);
      #1;
      check("wd_not_early", 32'({bus.host_ack, bus.err_timeout}), 0);
      @(posedge clk); #1;
      check("wd_abort", 32'({bus.host_ack, bus.err_timeout}), 32'd3);
      @(posedge clk); #1;
      bus.host_req = 1'b0;
      check("wd_back_idle", 32'({bus.grant_host, bus.err_timeout}), 0);
      busy_stuck = 1'b0;
`else
      repeat (40) @(posedge clk);
      #1;
      check("stuck_no_ack", 32'({bus.host_ack, bus.err_timeout}), 0);
      check("stuck_owner", 32'(bus.grant_host), 1);
      bus.host_req = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      busy_stuck = 1'b0;
      check("stuck_cleared", 32'(bus.grant_host), 0);
`endif
      repeat (5) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      check("total_starts", starts, 18);
      check("total_scan_acks", scan_acks, 11);
`ifdef MEMS_ARB_WATCHDOG_EN
      check("total_host_acks", host_acks, 6);
`else
      check("total_host_acks", host_acks, 5);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
